trans_bank: RTL and testbench

TRANS_BANK -- requirements
Module: trans_bank

---
 rtl/trans_pkg.sv | 23 ++
 rtl/trans_rr_arb.sv | 52 +++++
 rtl/trans_bank.sv | 232 +++++++++++++++++++++++
 tb/tb_trans_bank.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trans_pkg.sv
// Shared definitions for the transaction bank: engine states, default
// parameter values and an index-width helper.
package trans_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DONE  = 2'd2,
    S_CLEAR = 2'd3
  } state_e;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_OP_W        = 11;
  localparam int DEF_DEPTH       = 1256;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_BUSY_CYCLES = 1;

  // Bits needed to index n entries; never less than one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/trans_rr_arb.sv
// Round-robin arbiter: one-hot grant plus its index. Search starts at the
// pointer; the pointer moves one past the winner only when en is high.
module trans_rr_arb
  import trans_pkg::*;
#(
  parameter  int N  = DEF_NUM_CH,
  localparam int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand;
  logic          found;

  // Priority search from the pointer and next-pointer computation.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    gnt     = '0;
    gnt_idx = '0;
    ptr_d   = ptr_q;
    cand    = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (en && found) begin
      ptr_d = IW'((int'(gnt_idx) + 1) % N);
    end
  end

  // Pointer register; channel 0 has first priority after reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/trans_bank.sv
// Transaction bank: per-channel request slots, a round-robin engine that
// increments one totals counter per request, a clear sweep and a
// registered read port.
// Build option: define TRANS_BANK_SAT_EN to make counters saturate at
// all-ones (and raise sat_flag) instead of wrapping to zero.
module trans_bank
  import trans_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int OP_W        = DEF_OP_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int BUSY_CYCLES = DEF_BUSY_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      do_work,
  input  logic [NUM_CH*OP_W-1:0] op_code,
  output logic [NUM_CH-1:0]      do_ready,
  output logic [NUM_CH-1:0]      work_done,
  output logic                   err_oor,
  input  logic                   clear_all,
  output logic                   init_done,
  input  logic [OP_W-1:0]        rd_addr,
  output logic [CNT_W-1:0]       rd_data,
  output logic                   sat_flag
);

  localparam int          AW      = idx_w(DEPTH);
  localparam int          IW      = idx_w(NUM_CH);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  state_e                       state_q, state_d;
  logic [7:0]                   busy_cnt_q, busy_cnt_d;
  logic [IW-1:0]                gnt_idx_q, gnt_idx_d;
  logic                         oor_q, oor_d;
  logic [AW-1:0]                clr_addr_q, clr_addr_d;
  logic                         clr_pend_q, clr_pend_d;
  logic [NUM_CH-1:0]            pend_vld_q, pend_vld_d;
  logic [NUM_CH-1:0][OP_W-1:0]  pend_op_q, pend_op_d;
  logic [CNT_W-1:0]             rd_data_q, rd_data_d;
`ifdef TRANS_BANK_SAT_EN
  logic                         sat_q, sat_d;
`endif

  logic [CNT_W-1:0]  totals_mem [DEPTH];
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [CNT_W-1:0]  mem_wdata;

  logic [NUM_CH-1:0] arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              arb_en;
  logic [OP_W-1:0]   gnt_op;
  logic              gnt_in_range;
  logic [CNT_W-1:0]  cur_cnt;

  trans_rr_arb #(.N(NUM_CH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (pend_vld_q),
    .en      (arb_en),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Handshake and status outputs; reset forces them quiet combinationally.
  always_comb begin
    init_done = !rst && (state_q != S_CLEAR);
    do_ready  = ~pend_vld_q & {NUM_CH{init_done}};
    work_done = '0;
    if (state_q == S_DONE) begin
      work_done[gnt_idx_q] = 1'b1;
    end
    err_oor = (state_q == S_DONE) && oor_q;
    rd_data = rd_data_q;
`ifdef TRANS_BANK_SAT_EN
    sat_flag = sat_q;
`else
    sat_flag = 1'b0;
`endif
  end

  // Op of the winning slot and the counter it addresses.
  always_comb begin
    gnt_op = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (arb_gnt[c]) begin
        gnt_op = gnt_op | pend_op_q[c];
      end
    end
    gnt_in_range = 32'(gnt_op) < DEPTH_U;
    cur_cnt      = totals_mem[AW'(gnt_op)];
    rd_data_d    = (32'(rd_addr) < DEPTH_U) ? totals_mem[AW'(rd_addr)] : '0;
  end

  // Engine next-state: slot accept, grant + read-modify-write, busy count,
  // completion and the one-counter-per-cycle clear sweep.
  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    gnt_idx_d  = gnt_idx_q;
    oor_d      = oor_q;
    clr_addr_d = clr_addr_q;
    clr_pend_d = clr_pend_q;
    pend_vld_d = pend_vld_q;
    pend_op_d  = pend_op_q;
    mem_we     = 1'b0;
    mem_addr   = clr_addr_q;
    mem_wdata  = '0;
    arb_en     = 1'b0;
`ifdef TRANS_BANK_SAT_EN
    sat_d      = sat_q;
`endif

    for (int c = 0; c < NUM_CH; c++) begin
      if (do_work[c] && do_ready[c]) begin
        pend_vld_d[c] = 1'b1;
        pend_op_d[c]  = op_code[c*OP_W +: OP_W];
      end
    end

    // A clear arriving outside IDLE waits for the next IDLE entry.
    if (clear_all && (state_q != S_IDLE)) begin
      clr_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (clear_all || clr_pend_q) begin
          state_d    = S_CLEAR;
          clr_pend_d = 1'b0;
          clr_addr_d = '0;
`ifdef TRANS_BANK_SAT_EN
          sat_d      = 1'b0;
`endif
        end else if (|pend_vld_q) begin
          arb_en     = 1'b1;
          gnt_idx_d  = arb_idx;
          oor_d      = !gnt_in_range;
          busy_cnt_d = 8'(BUSY_CYCLES - 1);
          state_d    = S_BUSY;
          if (gnt_in_range) begin
            mem_we   = 1'b1;
            mem_addr = AW'(gnt_op);
`ifdef TRANS_BANK_SAT_EN
            if (&cur_cnt) begin
              mem_wdata = cur_cnt;
              sat_d     = 1'b1;
            end else begin
              mem_wdata = cur_cnt + CNT_W'(1);
            end
`else
            mem_wdata = cur_cnt + CNT_W'(1);
`endif
          end
        end
      end
      S_BUSY: begin
        if (busy_cnt_q == 8'd0) begin
          state_d = S_DONE;
        end else begin
          busy_cnt_d = busy_cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        pend_vld_d[gnt_idx_q] = 1'b0;
        state_d               = S_IDLE;
      end
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_addr_q;
        mem_wdata = '0;
        if (32'(clr_addr_q) == DEPTH_U - 32'd1) begin
          state_d = S_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end
      default: state_d = S_CLEAR;
    endcase

    if (rst) begin
      mem_we = 1'b0;
    end
  end

  // Control registers; reset abandons any op and restarts the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CLEAR;
      busy_cnt_q <= '0;
      gnt_idx_q  <= '0;
      oor_q      <= 1'b0;
      clr_addr_q <= '0;
      clr_pend_q <= 1'b0;
      pend_vld_q <= '0;
      pend_op_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
      gnt_idx_q  <= gnt_idx_d;
      oor_q      <= oor_d;
      clr_addr_q <= clr_addr_d;
      clr_pend_q <= clr_pend_d;
      pend_vld_q <= pend_vld_d;
      pend_op_q  <= pend_op_d;
      rd_data_q  <= rd_data_d;
    end
  end

`ifdef TRANS_BANK_SAT_EN
  // Sticky saturation flag, dropped when a sweep starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end
`endif

  // Totals storage: single write port shared by increments and the sweep.
  always_ff @(posedge clk) begin
    // NOTE: the counter array has no reset; the clear sweep that follows every reset zeroes it, which keeps it mappable to RAM.
    if (mem_we) begin
      totals_mem[mem_addr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_trans_bank.sv
// Directed self-checking bench for trans_bank (NUM_CH=4, OP_W=11,
// DEPTH=1256, CNT_W=4 so wrap/saturation is reachable, BUSY_CYCLES=1).
module tb_trans_bank;

  localparam int NUM_CH = 4;
  localparam int OP_W   = 11;
  localparam int DEPTH  = 1256;
  localparam int CNT_W  = 4;
  localparam int BUSY   = 1;

  logic                   clk;
  logic                   rst;
  logic [NUM_CH-1:0]      do_work;
  logic [NUM_CH*OP_W-1:0] op_code;
  logic [NUM_CH-1:0]      do_ready;
  logic [NUM_CH-1:0]      work_done;
  logic                   err_oor;
  logic                   clear_all;
  logic                   init_done;
  logic [OP_W-1:0]        rd_addr;
  logic [CNT_W-1:0]       rd_data;
  logic                   sat_flag;

  int n_checks;
  int n_errors;
  int wd_at [NUM_CH];
  bit err_seen;
  bit init_low;

  trans_bank #(
    .NUM_CH(NUM_CH), .OP_W(OP_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .BUSY_CYCLES(BUSY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .do_work   (do_work),
    .op_code   (op_code),
    .do_ready  (do_ready),
    .work_done (work_done),
    .err_oor   (err_oor),
    .clear_all (clear_all),
    .init_done (init_done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .sat_flag  (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic do_read(input int addr, output int val);
    rd_addr = OP_W'(addr);
    tick();
    val = int'(rd_data);
  endtask

  // Issue one request and measure edges from accept to the completion window.
  task automatic send(input int ch, input int op, output int lat, output logic err);
    int w;
    w = 0;
    while (!do_ready[ch] && w < 3000) begin
      tick();
      w++;
    end
    do_work[ch] = 1'b1;
    op_code[ch*OP_W +: OP_W] = OP_W'(op);
    @(posedge clk);
    @(negedge clk);
    do_work[ch] = 1'b0;
    lat = -1;
    err = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (work_done[ch]) begin
        lat = k;
        err = err_oor;
        break;
      end
      tick();
    end
    tick();
    check("wd_single_cycle", {31'd0, work_done[ch]}, 32'd0);
  endtask

  task automatic clr_watch();
    for (int c = 0; c < NUM_CH; c++) wd_at[c] = -1;
    err_seen = 1'b0;
    init_low = 1'b0;
  endtask

  // Record the first window index at which each channel completes.
  task automatic watch(input int k0, input int kmax);
    for (int k = k0; k <= kmax; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (work_done[c] && wd_at[c] < 0) wd_at[c] = k;
      end
      if (err_oor) err_seen = 1'b1;
      if (!init_done) init_low = 1'b1;
      if (k < kmax) tick();
    end
  endtask

  initial begin
    int   n;
    int   v;
    int   lat;
    logic err;

    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    do_work   = '0;
    op_code   = '0;
    clear_all = 1'b0;
    rd_addr   = '0;
    repeat (3) tick();

    // Reset state
    check("rst_ready", {28'd0, do_ready}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_work_done", {28'd0, work_done}, 32'd0);
    check("rst_err_oor", {31'd0, err_oor}, 32'd0);
    check("rst_sat_flag", {31'd0, sat_flag}, 32'd0);
    check("rst_rd_data", {28'd0, rd_data}, 32'd0);

    // Sweep after reset takes exactly DEPTH cycles
    rst = 1'b0;
    wait_init(n);
    check("init_latency", n, DEPTH);
    check("ready_after_init", {28'd0, do_ready}, 32'hF);
    do_read(5, v);
    check("rd_addr5", v, 0);

    // Single uncontended request: completion seen in window accept+2,
    // i.e. captured by edge accept+BUSY+2
    send(0, 7, lat, err);
    check("lat_ch0_op7", lat, BUSY + 1);
    check("err_ch0_op7", {31'd0, err}, 32'd0);
    do_read(7, v);
    check("totals7", v, 1);

    // Reset during BUSY: no completion, sweep restarts and clears counters
    do_work[1] = 1'b1;
    op_code[1*OP_W +: OP_W] = OP_W'(9);
    @(posedge clk);
    @(negedge clk);
    do_work[1] = 1'b0;
    tick();
    check("busy_slot_full", {31'd0, do_ready[1]}, 32'd0);
    rst = 1'b1;
    tick();
    check("midrst_ready", {28'd0, do_ready}, 32'd0);
    check("midrst_init", {31'd0, init_done}, 32'd0);
    tick();
    check("midrst_no_done", {28'd0, work_done}, 32'd0);
    rst = 1'b0;
    wait_init(n);
    check("reinit_latency", n, DEPTH);
    do_read(9, v);
    check("totals9_cleared", v, 0);
    do_read(7, v);
    check("totals7_cleared", v, 0);

    // All four channels at once: round-robin from channel 0, spaced BUSY+2
    clr_watch();
    do_work = '1;
    for (int c = 0; c < NUM_CH; c++) op_code[c*OP_W +: OP_W] = OP_W'(3);
    @(posedge clk);
    @(negedge clk);
    do_work = '0;
    watch(0, 14);
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("rr_done_ch%0d", c), wd_at[c], 2 + c * (BUSY + 2));
    end
    check("rr_no_err", {31'd0, err_seen}, 32'd0);
    do_read(3, v);
    check("totals3", v, 4);

    // Out-of-range op: err_oor with work_done, nothing written
    send(2, 2000, lat, err);
    check("lat_oor", lat, BUSY + 1);
    check("err_oor_pulse", {31'd0, err}, 32'd1);
    do_read(2000, v);
    check("rd_oor_addr", v, 0);
    do_read(3, v);
    check("totals3_unchanged", v, 4);

    // 17 hits on a 4-bit counter
    for (int i = 0; i < 17; i++) send(1, 1, lat, err);
    do_read(1, v);
`ifdef TRANS_BANK_SAT_EN
    check("totals1_sat", v, 15);
    check("sat_flag_set", {31'd0, sat_flag}, 32'd1);
`else
    check("totals1_wrap", v, 1);
    check("sat_flag_tied", {31'd0, sat_flag}, 32'd0);
`endif

    // clear_all during BUSY: ch0 finishes, sweep runs, queued ch1 follows
    clr_watch();
    do_work[0] = 1'b1;
    do_work[1] = 1'b1;
    op_code[0*OP_W +: OP_W] = OP_W'(3);
    op_code[1*OP_W +: OP_W] = OP_W'(4);
    @(posedge clk);
    @(negedge clk);
    do_work = '0;
    watch(0, 0);
    tick();
    watch(1, 1);
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    watch(2, DEPTH + 10);
    check("clr_ch0_done", wd_at[0], 2);
    check("clr_ch1_done", wd_at[1], DEPTH + 6);
    check("clr_init_low", {31'd0, init_low}, 32'd1);
    check("clr_no_err", {31'd0, err_seen}, 32'd0);
    check("clr_sat_cleared", {31'd0, sat_flag}, 32'd0);
    do_read(3, v);
    check("clr_totals3", v, 0);
    do_read(1, v);
    check("clr_totals1", v, 0);
    do_read(4, v);
    check("clr_totals4_after", v, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
